div_seq: RTL and testbench
==========================

// Module: div_seq
// PURPOSE
//  Iterative 32/32 divider with its sequencing FSM, serving DIV/DIVU in the execute stage.
//  EX raises start_i with operands and holds it, plus signed_div_i, until ready_o is seen.
//  stallreq_o feeds the pipeline stall controller, which stalls stages up to EX.
//  The {HI,LO} result reaches the EX/MEM register through the normal hi/lo write path.
// PARAMETERS
//  WIDTH      32  operand width; the result is 2*WIDTH bits
//  CNT_W      6   iteration counter width; must be >= clog2(WIDTH)+1
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       synchronous reset, active-high (RstEnable)
//  signed_div_i  in   1       1 = DIV (two's complement), 0 = DIVU
//  opdata1_i     in   WIDTH   dividend
//  opdata2_i     in   WIDTH   divisor
//  start_i       in   1       divide request, level, held by EX until done
//  annul_i       in   1       cancel the current/pending divide (flush)
//  result_o      out  2*WIDTH {remainder[63:32], quotient[31:0]} = {HI, LO}
//  ready_o       out  1       result_o valid; asserted only in state END
//  stallreq_o    out  1       combinational: start_i & ~annul_i & ~ready_o
// BEHAVIOUR
//  Reset: state FREE, ready_o=0, result_o=0, counter=0. This also applies mid-operation.
//  States:
//  - FREE: if start_i & ~annul_i: divisor==0 -> BYZERO; else ON.
//    Latch |a|,|b| (negate only if signed_div_i and MSB=1), the result signs, and cnt=0.
//    Otherwise stay; ready_o=0.
//  - ON: if annul_i -> FREE, and result_o is not updated.
//    Else while cnt!=WIDTH: restoring step (shift the partial remainder left 1, trial-subtract |b|;
//    if no borrow, keep the difference and shift in quotient bit 1, else 0); cnt++.
//    At cnt==WIDTH: apply signs (quotient negated if signs differ; remainder takes the dividend's sign),
//    load result_o, go to END.
//  - BYZERO: result_o=0, go to END (MIPS leaves this result architecturally undefined).
//  - END: ready_o=1 and result_o stable while start_i=1. When start_i=0 -> FREE, with ready_o=0 on the same edge.
//    annul_i in END -> FREE.
//  Latency (edges after the edge that samples start_i in FREE to ready_o=1): normal 34, divide-by-zero 2.
//  Boundaries:
//  - Signed 0x80000000 / 0xFFFFFFFF wraps: q=0x80000000, r=0. No trap.
//  - |b|=0x80000000 handled as a WIDTH-bit unsigned magnitude. The partial remainder is WIDTH+1 bits.
//  - Operand changes after acceptance are ignored; operands are latched in FREE.
//  - start_i and annul_i high together in FREE: no start.
//  - stallreq_o must drop in the same cycle that ready_o rises.
// CONFIGURATION
//  DIV_EARLY_TERM_EN defined: in FREE, a nonzero divisor with |a|<|b| skips ON.
//    The FSM goes straight to END with q=0 and r=opdata1_i (original signed value); latency 1 edge.
//    Divide-by-zero is checked first.
//  DIV_EARLY_TERM_EN undefined: every nonzero-divisor case takes 34 edges.
//  Results are identical either way; only the latency differs.
// TESTING
//  1. DIVU 100/7, start held -> ready_o at edge 34, result_o=0x00000002_0000000E. stallreq_o=1 for exactly 34 cycles.
//  2. DIV -7/2 -> result_o=0xFFFFFFFF_FFFFFFFD (r=-1, q=-3).
//     DIV 7/-2 -> result_o=0x00000001_FFFFFFFD (r=+1, q=-3).
//  3. DIV 0x80000000/0xFFFFFFFF -> result_o=0x00000000_80000000, no hang.
//     DIVU 5/0 -> ready_o after 2 edges, result_o=0.
//  4. annul_i pulsed at iteration 10 -> FREE next edge, ready_o never rises, result_o unchanged.
//     Next start, 9/3 unsigned -> 0x00000000_00000003 at edge 34.
//  5. Hold start_i 5 cycles in END -> ready_o=1 and result_o constant.
//     Drop start_i -> ready_o=0 next edge. rst asserted mid-ON -> all outputs 0, state FREE.
//  6. DIVU 3/10: with DIV_EARLY_TERM_EN -> ready_o after 1 edge; without -> 34. Both give result_o=0x00000003_00000000.

Source files
------------

// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq -- iterative restoring divider for DIV/DIVU in the execute stage.
//
// result_o = {remainder, quotient} = {HI, LO}. EX holds start_i and
// signed_div_i until ready_o; stallreq_o stalls the pipeline meanwhile.
//
// Optional feature macro: DIV_EARLY_TERM_EN
//   defined   : a nonzero divisor with |a| < |b| skips the iteration loop and
//               finishes with q = 0, r = dividend (ready one edge after start).
//   undefined : every nonzero-divisor divide runs the full WIDTH iterations.
// Results are identical either way; only latency differs.
// ---------------------------------------------------------------------------
module div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_ON     = 2'd1,
    S_BYZERO = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Latched operand magnitudes, sign bookkeeping and iteration state.
  logic [WIDTH-1:0] quo_q;      // dividend shifts out MSB-first, quotient shifts in
  logic [WIDTH-1:0] rem_q;      // partial remainder (always < divisor)
  logic [WIDTH-1:0] dvs_q;      // |divisor|, kept as an unsigned WIDTH-bit magnitude
  logic             neg_quo_q;  // quotient must be negated at the end
  logic             neg_rem_q;  // remainder takes the dividend's sign
  logic [CNT_W-1:0] cnt_q;

  // Operand conditioning in FREE: negate only for signed divides with MSB set.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero;
  logic             accept;

  assign a_neg    = signed_div_i & opdata1_i[WIDTH-1];
  assign b_neg    = signed_div_i & opdata2_i[WIDTH-1];
  assign a_mag    = a_neg ? -opdata1_i : opdata1_i;
  assign b_mag    = b_neg ? -opdata2_i : opdata2_i;
  assign div_zero = (opdata2_i == '0);
  // A simultaneous flush wins over a new request.
  assign accept   = (state_q == S_FREE) & start_i & ~annul_i;

`ifdef DIV_EARLY_TERM_EN
  logic early_done;
  // |a| < |b| means q = 0 and r = a, so the loop can be skipped.
  assign early_done = ~div_zero & (a_mag < b_mag);
`endif

  // One restoring step: the shifted partial remainder is WIDTH+1 bits so a
  // divisor magnitude of 2^(WIDTH-1) still compares correctly; one extra bit
  // on the subtraction exposes the borrow.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             borrow;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic             cnt_done;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign trial    = {1'b0, shifted} - {2'b00, dvs_q};
  assign borrow   = trial[WIDTH+1];
  assign rem_step = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_step = {quo_q[WIDTH-2:0], ~borrow};
  assign cnt_done = (cnt_q == CNT_W'(WIDTH));

  // Sign correction; the most negative quotient wraps onto itself, no trap.
  assign quo_fix  = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix  = neg_rem_q ? -rem_q : rem_q;

  // Stall while a request is outstanding and its result is not yet valid;
  // it falls in the same cycle ready_o rises.
  assign stallreq_o = start_i & ~annul_i & ~ready_o;

  // State register with synchronous reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FREE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FREE: begin
        if (accept) begin
          if (div_zero) begin
            state_d = S_BYZERO;
          end else begin
`ifdef DIV_EARLY_TERM_EN
            state_d = early_done ? S_END : S_ON;
`else
            state_d = S_ON;
`endif
          end
        end
      end
      S_ON: begin
        if (annul_i)       state_d = S_FREE;
        else if (cnt_done) state_d = S_END;
      end
      S_BYZERO: begin
        state_d = S_END;
      end
      S_END: begin
        if (annul_i || !start_i) state_d = S_FREE;
      end
      default: state_d = S_FREE;
    endcase
  end

  // Datapath: operand latch, iteration, result load and the ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      result_o  <= '0;
      ready_o   <= 1'b0;
    end else begin
      // ready_o is registered: it rises on the first edge spent in END and
      // clears on the edge that leaves END.
      ready_o <= (state_q == S_END) & start_i & ~annul_i;

      unique case (state_q)
        S_FREE: begin
          if (accept) begin
            quo_q     <= a_mag;
            rem_q     <= '0;
            dvs_q     <= b_mag;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            cnt_q     <= '0;
`ifdef DIV_EARLY_TERM_EN
            if (early_done) result_o <= {opdata1_i, {WIDTH{1'b0}}};
`endif
          end
        end
        S_ON: begin
          // A flush abandons the divide and leaves result_o untouched.
          if (!annul_i) begin
            if (!cnt_done) begin
              quo_q <= quo_step;
              rem_q <= rem_step;
              cnt_q <= cnt_q + CNT_W'(1);
            end else begin
              result_o <= {rem_fix, quo_fix};
            end
          end
        end
        S_BYZERO: begin
          // Architecturally undefined result; zero keeps it deterministic.
          result_o <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// ---------------------------------------------------------------------------
// tb_div_seq -- directed self-checking bench for div_seq.
// Expected results and latencies are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready, stallreq;

  int n_checks = 0;
  int n_errors = 0;

`ifdef DIV_EARLY_TERM_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 34;
`endif

  always #5 clk = ~clk;

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stallreq)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Issue one divide with start held; check latency, stall length, result,
  // that the result holds for 'hold' extra cycles, and that dropping start
  // clears ready on the next edge.
  task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp,
                         input int exp_lat, input int hold);
    int lat;
    int stalls;
    @(negedge clk);
    signed_div = sd; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
    @(posedge clk); #1;              // edge 0 samples the request
    op1 = ~a; op2 = b ^ 32'h5A5A_0001;  // later operand changes must be ignored
    lat = 0;
    stalls = 0;
    while (!ready && lat < 100) begin
      stalls += int'(stallreq);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_lat));
    check({tag, "_result"}, result, exp);
    check({tag, "_stall_low"}, 64'(stallreq), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_ready"}, 64'(ready), 64'd1);
      check({tag, "_hold_result"}, result, exp);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, "_drop_ready"}, 64'(ready), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen_ready;
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    op1 = '0; op2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_stall", 64'(stallreq), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic unsigned and signed divides.
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, 0);
    run_div("div_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34, 0);
    run_div("div_7_m2",   1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 34, 0);
    run_div("div_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 34, 0);
    run_div("divu_by0",   1'b0, 32'd5, 32'd0, 64'd0, 2, 0);
    run_div("divu_bigb",  1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 64'h7FFFFFFF_00000001, 34, 0);

    // Flush at iteration 10: no ready, previous result kept.
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    #1;
    check("annul_stall", 64'(stallreq), 64'd0);
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    seen_ready = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen_ready |= ready;
    end
    check("annul_no_ready", 64'(seen_ready), 64'd0);
    check("annul_result_kept", result, 64'h7FFFFFFF_00000001);

    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34, 5);

    // start and annul together in FREE: no divide begins.
    @(negedge clk);
    op1 = 32'd100; op2 = 32'd7; start = 1'b1; annul = 1'b1;
    #1;
    check("start_annul_stall", 64'(stallreq), 64'd0);
    seen_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      seen_ready |= ready;
    end
    check("start_annul_no_ready", 64'(seen_ready), 64'd0);
    check("start_annul_result", result, 64'h00000000_00000003);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;

    // Synchronous reset in the middle of an iteration.
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("midrst_ready", 64'(ready), 64'd0);
    check("midrst_result", result, 64'd0);
    check("midrst_stall", 64'(stallreq), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // |a| < |b|: early finish when enabled, full length otherwise.
    run_div("divu_3_10", 1'b0, 32'd3, 32'd10, 64'h00000003_00000000, EARLY_LAT, 0);
    run_div("div_m3_10", 1'b1, 32'hFFFF_FFFD, 32'd10, 64'hFFFFFFFD_00000000, EARLY_LAT, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
